// File: rtl/morse_keyer.sv
// Morse keyer: plays one latched element pattern (dots/dashes) on the key line
// with standard unit timing, or a 7-unit word space when length is zero.
module morse_keyer #(
   parameter int unsigned UNIT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] morse,
   input  logic [2:0] length,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       key,
   output logic       busy,
   output logic       done
);

   localparam int unsigned    PW         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MARK     = 2'd1,
      ELEM_GAP = 2'd2,
      CHAR_GAP = 2'd3
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   presc_q;
   logic [2:0]      units_q;
   logic [2:0]      idx_q;
   logic [7:0]      pat_q;
   logic            key_q;
   logic            busy_q;
   logic            done_q;

   logic [2:0]      len_m1_s;
   logic [2:0]      idx_m1_s;
   logic            unit_tick_s;

   assign len_m1_s    = length - 3'd1;
   assign idx_m1_s    = idx_q - 3'd1;
   assign unit_tick_s = (presc_q == PRESC_LAST);

   // Main FSM: prescaler, remaining-unit counter, element index and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         units_q <= 3'd0;
         idx_q   <= 3'd0;
         pat_q   <= 8'd0;
         key_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               presc_q <= '0;
               if (in_valid) begin
                  pat_q  <= morse;
                  busy_q <= 1'b1;
                  if (length != 3'd0) begin
                     state_q <= MARK;
                     idx_q   <= len_m1_s;
                     units_q <= morse[len_m1_s] ? 3'd3 : 3'd1;
                     key_q   <= 1'b1;
                  end else begin
                     state_q <= CHAR_GAP;
                     idx_q   <= 3'd0;
                     units_q <= 3'd7;
                     key_q   <= 1'b0;
                  end
               end else begin
                  busy_q <= 1'b0;
                  key_q  <= 1'b0;
               end
            end
            default: begin
               // Segment ends on the last prescaler cycle of its last unit
               if (unit_tick_s) begin
                  presc_q <= '0;
                  if (units_q == 3'd1) begin
                     case (state_q)
                        MARK: begin
                           key_q <= 1'b0;
                           if (idx_q != 3'd0) begin
                              state_q <= ELEM_GAP;
                              units_q <= 3'd1;
                           end else begin
                              state_q <= CHAR_GAP;
                              units_q <= 3'd3;
                           end
                        end
                        ELEM_GAP: begin
                           state_q <= MARK;
                           idx_q   <= idx_m1_s;
                           units_q <= pat_q[idx_m1_s] ? 3'd3 : 3'd1;
                           key_q   <= 1'b1;
                        end
                        default: begin
                           state_q <= IDLE;
                           units_q <= 3'd0;
                           key_q   <= 1'b0;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                        end
                     endcase
                  end else begin
                     units_q <= units_q - 3'd1;
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
         endcase
      end
   end

   assign in_ready = (state_q == IDLE);
   assign key      = key_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 Parameter UNIT_CYCLES, default 1000: clock cycles per Morse time unit; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 morse  input  8  element pattern; 1 = dash, 0 = dot; same format as the encoder stage's morse output.
REQ-005 length  input  3  number of elements, 0..7; 0 = word space.
REQ-006 in_valid  input  1  morse/length valid this cycle.
REQ-007 in_ready  output  1  keyer can accept a character this cycle.
REQ-008 key  output  1  keying line; 1 = tone/mark, 0 = space; registered.
REQ-009 busy  output  1  a character or word space is in progress; registered.
REQ-010 done  output  1  one-cycle pulse when a character or word space completes; registered.

Function
REQ-011 Handshake: accept when in_valid && in_ready at a rising edge; morse and length are latched only on accept.
REQ-012 in_ready SHALL equal (state == IDLE), combinationally from registered state; no other gating.
REQ-013 Input changes, and in_valid asserted while busy, SHALL be ignored with no effect on output timing.
REQ-014 Element order: first element is morse[length-1], last is morse[0]; bits morse[7:length] are ignored.
REQ-015 Durations: dot = 1 unit key=1; dash = 3 units key=1; gap between elements = 1 unit key=0; gap after the last element = 3 units key=0.
REQ-016 length == 0 SHALL produce 7 units of key=0 and no mark.
REQ-017 One unit SHALL be exactly UNIT_CYCLES clock cycles, with no drift between units.
REQ-018 FSM states: IDLE, MARK, ELEM_GAP, CHAR_GAP.
- IDLE: accept with length>0 -> MARK; accept with length==0 -> CHAR_GAP loaded with 7 units.
- MARK: end of mark -> ELEM_GAP if elements remain, else CHAR_GAP (3 units).
- ELEM_GAP: end -> MARK with next element.
- CHAR_GAP: end -> IDLE.
REQ-019 Latency: key (and busy) SHALL first change in the cycle after the accept edge.
REQ-020 A character of U total units SHALL occupy exactly U*UNIT_CYCLES cycles with busy=1.
REQ-021 In the first cycle after the busy period: busy=0, in_ready=1, done=1 for exactly that cycle.
REQ-022 Back-to-back: an accept in the done cycle SHALL start the next character on the following cycle, with no extra idle cycles.
REQ-023 key SHALL be 0 in IDLE, ELEM_GAP and CHAR_GAP, and 1 only in MARK.
REQ-024 Counters: prescaler width ceil(log2(UNIT_CYCLES)); unit counter 3 bits (max 7); element index 3 bits; no wrap within a character.

Reset
REQ-025 While rst=1 at an edge: state=IDLE, key=0, busy=0, done=0, all counters and latched pattern cleared; in_ready=1 in the cycle after.
REQ-026 rst asserted mid-character SHALL abort it immediately, with no done pulse and no residual mark.
REQ-027 rst has priority over a simultaneous in_valid; that character is not accepted.

Verification (UNIT_CYCLES=4, accept at cycle 0)
REQ-028 Reset: rst for 2 cycles with in_valid=1 -> key=0, busy=0, done=0 throughout; in_ready=1 after release.
REQ-029 'A': morse=8'b00000001, length=2 -> key=1 cycles 1-4, 0 cycles 5-8, 1 cycles 9-20, 0 cycles 21-32; done=1 and in_ready=1 at cycle 33.
REQ-030 'E' then 'T' back-to-back:
- 'E' (morse=0, length=1): key=1 cycles 1-4, 0 cycles 5-16, done at cycle 17.
- 'T' (morse=1, length=1), accepted at cycle 17: key=1 cycles 18-29.
REQ-031 Word space: length=0 -> key=0 and busy=1 for cycles 1-28; done at cycle 29.
REQ-032 Busy ignore: assert in_valid with a different pattern during 'A' -> waveform identical to REQ-029.
REQ-033 Mid-char reset: rst at cycle 10 during 'A' -> key=0, busy=0 from cycle 11, no done pulse; a new accept at cycle 12 keys normally from cycle 13.
